shifter_ctrl: RTL and testbench
===============================

SHIFTER_CTRL -- requirements
Module: shifter_ctrl

Interface
REQ-001: Parameter DW, default 32, data/mask width of the controlled shifter.
REQ-002: Parameter DL, default 5 (clog2(DW)), pipeline depth of the controlled shifter in cycles.
REQ-003: Parameter CLR_CYC, default 5, number of cycles ctl_clr is held in CLEAR.
REQ-004: Parameter DRAIN_TO, default 64, maximum DRAIN cycles before forced exit.
REQ-005: clk  input  1  single clock, all state updates on rising edge.
REQ-006: rst  input  1  asynchronous, active-high reset.
REQ-007: cmd_run  input  1  single-cycle request to start the shifter.
REQ-008: cmd_stop  input  1  single-cycle request to stop after draining.
REQ-009: cfg_wr  input  1  write strobe for a new mask.
REQ-010: cfg_wdata  input  DW  new mask value, sampled when cfg_wr=1.
REQ-011: mon_in  input  1  one beat accepted into the shifter (sti_valid & sti_ready) this cycle.
REQ-012: mon_out  input  1  one beat delivered by the shifter (sto_valid & sto_ready) this cycle.
REQ-013: ctl_clr  output  1  clear strobe to the shifter.
REQ-014: ctl_ena  output  1  shifter enable; 0 selects combinational bypass.
REQ-015: cfg_mask  output  DW  active mask driven to the shifter.
REQ-016: sti_hold  output  1  gates upstream sti_valid; 1 blocks new beats.
REQ-017: cfg_pending  output  1  shadow mask waiting to be applied.
REQ-018: state  output  3  current FSM state encoding.
REQ-019: inflight  output  clog2(DL+2)  beats inside the shifter pipeline.
REQ-020: err_timeout, err_underflow  output  1 each  sticky error flags.

Function
REQ-021: States: IDLE=0, CLEAR=1, RUN=2, DRAIN=3, UPDATE=4; codes 5-7 return to IDLE next cycle.
REQ-022: All outputs are registered; per-state values: IDLE ena=0 clr=0 hold=0; CLEAR ena=0 clr=1 hold=1; RUN ena=1 clr=0 hold=0; DRAIN ena=1 clr=0 hold=1; UPDATE ena=0 clr=0 hold=1.
REQ-023: IDLE: cfg_wr loads cfg_wdata into cfg_mask next cycle; cmd_run -> CLEAR and clears both error flags.
REQ-024: CLEAR: lasts exactly CLR_CYC cycles; inflight forced to 0; -> RUN.
REQ-025: RUN: inflight += mon_in - mon_out each cycle (both set: unchanged); saturates at DL+1.
REQ-026: RUN: cfg_wr latches cfg_wdata into shadow, sets cfg_pending, -> DRAIN with return target RUN.
REQ-027: RUN: cmd_stop -> DRAIN with return target IDLE.
REQ-028: Same-cycle priority in RUN: cmd_stop > cfg_wr > cmd_run; cfg_wr coincident with cmd_stop is still latched to shadow.
REQ-029: cfg_wr in DRAIN or UPDATE overwrites shadow (last write wins) and keeps cfg_pending=1.
REQ-030: cmd_run in CLEAR, DRAIN or UPDATE is ignored; cmd_stop in DRAIN sets return target to IDLE.
REQ-031: DRAIN: inflight decrements on mon_out; mon_in still counted; exit when inflight=0 at the cycle boundary.
REQ-032: DRAIN exit: -> UPDATE if cfg_pending, else -> return target (RUN only if target RUN).
REQ-033: DRAIN timeout: after DRAIN_TO cycles without reaching inflight=0, set err_timeout, force inflight=0, exit per REQ-032.
REQ-034: UPDATE: one cycle; cfg_mask <= shadow, cfg_pending <= 0; -> CLEAR if target RUN, else IDLE.
REQ-035: mon_out with inflight=0 leaves inflight at 0 and sets err_underflow.
REQ-036: inflight, when ctl_ena=0 (IDLE/CLEAR/UPDATE), does not count monitor inputs.

Reset
REQ-037: rst=1 asynchronously forces: state=IDLE, ctl_clr=0, ctl_ena=0, sti_hold=0, cfg_mask=0, shadow=0, cfg_pending=0, inflight=0, both error flags=0, return target=IDLE.
REQ-038: Reset asserted mid-operation (any state) discards shadow and pending update; first edge after release evaluates from IDLE.

Verification
REQ-039: Reset release, cmd_run pulse -> ctl_clr=1 for 5 cycles, then state=RUN, ctl_ena=1, inflight=0.
REQ-040: In RUN, 3 mon_in pulses then cfg_wr (0x0000_00FF) -> DRAIN, sti_hold=1; 3 mon_out pulses -> UPDATE, cfg_mask=0x0000_00FF, then CLEAR 5 cycles, RUN.
REQ-041: In RUN with inflight=2, cmd_stop and cfg_wr(0xA5A5_A5A5) same cycle -> DRAIN, after 2 mon_out -> UPDATE -> IDLE, cfg_mask=0xA5A5_A5A5, ctl_ena=0.
REQ-042: In DRAIN with inflight=1, no mon_out for 64 cycles -> err_timeout=1, exit per target; next cmd_run clears err_timeout.
REQ-043: In RUN inflight=0, mon_out pulse -> err_underflow=1, inflight stays 0; simultaneous mon_in+mon_out with inflight=1 -> inflight stays 1.
REQ-044: rst pulse during DRAIN with cfg_pending=1 -> all outputs at REQ-037 values immediately, cfg_mask=0.

Source files
------------

// File: rtl/shifter_ctrl_if.sv
// Command, configuration and monitor bundle between shifter_ctrl and its environment.
interface shifter_ctrl_if #(
  parameter int DW = 32,
  parameter int DL = 5
);
  localparam int IW = $clog2(DL + 2);

  logic          cmd_run;
  logic          cmd_stop;
  logic          cfg_wr;
  logic [DW-1:0] cfg_wdata;
  logic          mon_in;
  logic          mon_out;
  logic          ctl_clr;
  logic          ctl_ena;
  logic [DW-1:0] cfg_mask;
  logic          sti_hold;
  logic          cfg_pending;
  logic [2:0]    state;
  logic [IW-1:0] inflight;
  logic          err_timeout;
  logic          err_underflow;

  modport master (
    output cmd_run, cmd_stop, cfg_wr, cfg_wdata, mon_in, mon_out,
    input  ctl_clr, ctl_ena, cfg_mask, sti_hold, cfg_pending, state,
           inflight, err_timeout, err_underflow
  );

  modport slave (
    input  cmd_run, cmd_stop, cfg_wr, cfg_wdata, mon_in, mon_out,
    output ctl_clr, ctl_ena, cfg_mask, sti_hold, cfg_pending, state,
           inflight, err_timeout, err_underflow
  );
endinterface

// File: rtl/shifter_ctrl.sv
// Run/stop/mask-update sequencer for a pipelined shifter: drains in-flight beats
// before swapping the mask, then clears the pipeline and resumes.
module shifter_ctrl #(
  parameter int DW       = 32,
  parameter int DL       = 5,
  parameter int CLR_CYC  = 5,
  parameter int DRAIN_TO = 64
) (
  input logic           clk,
  input logic           rst,
  shifter_ctrl_if.slave bus
);
  localparam int IW   = $clog2(DL + 2);
  localparam int CMAX = (CLR_CYC > DRAIN_TO) ? CLR_CYC : DRAIN_TO;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [IW-1:0] FULL = IW'(DL + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    UPDATE = 3'd4
  } state_t;

  state_t        state_q, state_nx;
  logic [CW-1:0] cyc_cnt;
  logic [DW-1:0] mask_q, shadow_q;
  logic          pend_q, target_run_q;
  logic [IW-1:0] infl_q, infl_step;
  logic          eto_q, eun_q;
  logic          clr_q, ena_q, hold_q;
  logic          clr_d, ena_d, hold_d;
  logic          active, clr_last, drain_empty, drain_expired;
  logic          pend_eff, target_eff;

  // Beat counter step, saturating at DL+1 and floored at zero.
  function automatic logic [IW-1:0] count_step(logic [IW-1:0] cur, logic inc, logic dec);
    if (inc && !dec) return (cur == FULL) ? cur : cur + 1'b1;
    if (dec && !inc) return (cur == '0) ? cur : cur - 1'b1;
    return cur;
  endfunction

  assign active        = (state_q == RUN) || (state_q == DRAIN);
  assign infl_step     = active ? count_step(infl_q, bus.mon_in, bus.mon_out) : infl_q;
  assign clr_last      = (cyc_cnt == CW'(CLR_CYC - 1));
  assign drain_empty   = (infl_step == '0);
  assign drain_expired = (cyc_cnt == CW'(DRAIN_TO - 1));
  assign pend_eff      = pend_q | bus.cfg_wr;
  assign target_eff    = target_run_q & ~bus.cmd_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nx;
  end

  always_comb begin
    state_nx = IDLE;
    case (state_q)
      IDLE:   state_nx = bus.cmd_run ? CLEAR : IDLE;
      CLEAR:  state_nx = clr_last ? RUN : CLEAR;
      RUN:    state_nx = (bus.cmd_stop || bus.cfg_wr) ? DRAIN : RUN;
      DRAIN: begin
        if (drain_empty || drain_expired)
          state_nx = pend_eff ? UPDATE : (target_eff ? RUN : IDLE);
        else
          state_nx = DRAIN;
      end
      UPDATE: state_nx = target_run_q ? CLEAR : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with state_q.
  always_comb begin
    clr_d  = 1'b0;
    ena_d  = 1'b0;
    hold_d = 1'b0;
    case (state_nx)
      CLEAR:  begin clr_d = 1'b1; hold_d = 1'b1; end
      RUN:    ena_d = 1'b1;
      DRAIN:  begin ena_d = 1'b1; hold_d = 1'b1; end
      UPDATE: hold_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_q  <= 1'b0;
      ena_q  <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      clr_q  <= clr_d;
      ena_q  <= ena_d;
      hold_q <= hold_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt      <= '0;
      mask_q       <= '0;
      shadow_q     <= '0;
      pend_q       <= 1'b0;
      target_run_q <= 1'b0;
      infl_q       <= '0;
      eto_q        <= 1'b0;
      eun_q        <= 1'b0;
    end else begin
      infl_q <= infl_step;
      if (state_nx != state_q)
        cyc_cnt <= '0;
      else if (state_q == CLEAR || state_q == DRAIN)
        cyc_cnt <= cyc_cnt + 1'b1;
      if (active && bus.mon_out && !bus.mon_in && infl_q == '0)
        eun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (bus.cfg_wr) mask_q <= bus.cfg_wdata;
          if (bus.cmd_run) begin
            eto_q <= 1'b0;
            eun_q <= 1'b0;
          end
        end
        CLEAR: infl_q <= '0;
        RUN: begin
          if (bus.cfg_wr) begin
            shadow_q <= bus.cfg_wdata;
            pend_q   <= 1'b1;
          end
          if (bus.cmd_stop)    target_run_q <= 1'b0;
          else if (bus.cfg_wr) target_run_q <= 1'b1;
        end
        DRAIN: begin
          if (bus.cfg_wr) begin
            shadow_q <= bus.cfg_wdata;
            pend_q   <= 1'b1;
          end
          if (bus.cmd_stop) target_run_q <= 1'b0;
          if (!drain_empty && drain_expired) begin
            eto_q  <= 1'b1;
            infl_q <= '0;
          end
        end
        UPDATE: begin
          mask_q <= shadow_q;
          // A write landing during the swap is kept for the next drain.
          if (bus.cfg_wr) shadow_q <= bus.cfg_wdata;
          else            pend_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.state         = state_q;
  assign bus.ctl_clr       = clr_q;
  assign bus.ctl_ena       = ena_q;
  assign bus.sti_hold      = hold_q;
  assign bus.cfg_mask      = mask_q;
  assign bus.cfg_pending   = pend_q;
  assign bus.inflight      = infl_q;
  assign bus.err_timeout   = eto_q;
  assign bus.err_underflow = eun_q;
endmodule

// File: tb/tb_shifter_ctrl.sv
// Bench for shifter_ctrl: directed vector table, corner sequences and randomized
// traffic compared against a cycle-level behavioural model.
module tb_shifter_ctrl;
  localparam int DW = 32, DL = 5, CLR_CYC = 5, DRAIN_TO = 64;
  localparam int S_IDLE = 0, S_CLEAR = 1, S_RUN = 2, S_DRAIN = 3, S_UPDATE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  shifter_ctrl_if #(.DW(DW), .DL(DL)) bus ();
  shifter_ctrl #(.DW(DW), .DL(DL), .CLR_CYC(CLR_CYC), .DRAIN_TO(DRAIN_TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          m_state, m_time, m_infl;
  logic [31:0] m_mask, m_shadow;
  logic        m_pend, m_target_run, m_eto, m_eun;

  typedef struct {
    logic run, stop, wr;
    logic [31:0] wd;
    logic mi, mo;
    int st;
    logic [2:0] ctl;
    logic pend;
    int infl;
    logic [31:0] mask;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [43:0] mk(int st, logic [2:0] ctl, logic pend, int infl,
                                     logic eto, logic eun, logic [31:0] mask);
    logic [2:0] s3, i3;
    s3 = st[2:0];
    i3 = infl[2:0];
    return {s3, ctl, pend, i3, eto, eun, mask};
  endfunction

  function automatic logic [43:0] act_vec();
    return {bus.state, bus.ctl_clr, bus.ctl_ena, bus.sti_hold, bus.cfg_pending,
            bus.inflight, bus.err_timeout, bus.err_underflow, bus.cfg_mask};
  endfunction

  function automatic logic [43:0] model_vec();
    logic [2:0] ctl;
    ctl = {m_state == S_CLEAR, m_state == S_RUN || m_state == S_DRAIN,
           m_state == S_CLEAR || m_state == S_DRAIN || m_state == S_UPDATE};
    return mk(m_state, ctl, m_pend, m_infl, m_eto, m_eun, m_mask);
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_time = 0; m_infl = 0;
    m_mask = '0; m_shadow = '0; m_pend = 0; m_target_run = 0; m_eto = 0; m_eun = 0;
  endtask

  // One clock of the controller, expressed directly from the behavioural rules.
  task automatic model_step(input logic r, s, w, input logic [31:0] wd, input logic mi, mo);
    int nxt = m_state;
    int fl  = m_infl;
    if (m_state == S_RUN || m_state == S_DRAIN) begin
      if (mi && !mo && fl < DL + 1) fl = fl + 1;
      else if (mo && !mi) begin
        if (fl == 0) m_eun = 1;
        else fl = fl - 1;
      end
    end
    case (m_state)
      S_IDLE: begin
        if (w) m_mask = wd;
        if (r) begin nxt = S_CLEAR; m_eto = 0; m_eun = 0; end
      end
      S_CLEAR: begin
        fl = 0;
        if (m_time == CLR_CYC - 1) nxt = S_RUN;
      end
      S_RUN: begin
        if (w) begin m_shadow = wd; m_pend = 1; end
        if (s) begin m_target_run = 0; nxt = S_DRAIN; end
        else if (w) begin m_target_run = 1; nxt = S_DRAIN; end
      end
      S_DRAIN: begin
        if (w) begin m_shadow = wd; m_pend = 1; end
        if (s) m_target_run = 0;
        if (fl == 0 || m_time == DRAIN_TO - 1) begin
          if (fl != 0) begin m_eto = 1; fl = 0; end
          nxt = m_pend ? S_UPDATE : (m_target_run ? S_RUN : S_IDLE);
        end
      end
      S_UPDATE: begin
        m_mask = m_shadow;
        if (w) m_shadow = wd;
        else m_pend = 0;
        nxt = m_target_run ? S_CLEAR : S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
    m_time  = (nxt == m_state) ? m_time + 1 : 0;
    m_state = nxt;
    m_infl  = fl;
  endtask

  task automatic chk(input string nm, input logic [43:0] exp);
    logic [43:0] act;
    act = act_vec();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (st,clr/ena/hold,pend,infl,eto,eun,mask) t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick(input logic r, s, w, input logic [31:0] wd, input logic mi, mo);
    bus.cmd_run = r; bus.cmd_stop = s; bus.cfg_wr = w;
    bus.cfg_wdata = wd; bus.mon_in = mi; bus.mon_out = mo;
    @(posedge clk);
    model_step(r, s, w, wd, mi, mo);
    #1;
    chk("model", model_vec());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0, 32'h0, 0, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_run = 0; bus.cmd_stop = 0; bus.cfg_wr = 0;
    bus.cfg_wdata = '0; bus.mon_in = 0; bus.mon_out = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset", mk(S_IDLE, 3'b000, 0, 0, 0, 0, 32'h0));
    @(negedge clk);
    rst = 0;

    // Start, fill, mask update with return to RUN, then stop with coincident write.
    tbl.push_back('{1, 0, 0, 32'h0, 0, 0, S_CLEAR, 3'b101, 0, 0, 32'h0});
    for (int k = 0; k < 4; k++)
      tbl.push_back('{0, 0, 0, 32'h0, 0, 0, S_CLEAR, 3'b101, 0, 0, 32'h0});
    tbl.push_back('{0, 0, 0, 32'h0, 0, 0, S_RUN,    3'b010, 0, 0, 32'h0});
    tbl.push_back('{0, 0, 0, 32'h0, 1, 0, S_RUN,    3'b010, 0, 1, 32'h0});
    tbl.push_back('{0, 0, 0, 32'h0, 1, 0, S_RUN,    3'b010, 0, 2, 32'h0});
    tbl.push_back('{0, 0, 0, 32'h0, 1, 0, S_RUN,    3'b010, 0, 3, 32'h0});
    tbl.push_back('{0, 0, 1, 32'h0000_00FF, 0, 0, S_DRAIN, 3'b011, 1, 3, 32'h0});
    tbl.push_back('{0, 0, 0, 32'h0, 0, 1, S_DRAIN,  3'b011, 1, 2, 32'h0});
    tbl.push_back('{0, 0, 0, 32'h0, 0, 1, S_DRAIN,  3'b011, 1, 1, 32'h0});
    tbl.push_back('{0, 0, 0, 32'h0, 0, 1, S_UPDATE, 3'b001, 1, 0, 32'h0});
    for (int k = 0; k < 5; k++)
      tbl.push_back('{0, 0, 0, 32'h0, 0, 0, S_CLEAR, 3'b101, 0, 0, 32'h0000_00FF});
    tbl.push_back('{0, 0, 0, 32'h0, 0, 0, S_RUN,    3'b010, 0, 0, 32'h0000_00FF});
    tbl.push_back('{0, 0, 0, 32'h0, 1, 0, S_RUN,    3'b010, 0, 1, 32'h0000_00FF});
    tbl.push_back('{0, 0, 0, 32'h0, 1, 0, S_RUN,    3'b010, 0, 2, 32'h0000_00FF});
    tbl.push_back('{0, 1, 1, 32'hA5A5_A5A5, 0, 0, S_DRAIN, 3'b011, 1, 2, 32'h0000_00FF});
    tbl.push_back('{0, 0, 0, 32'h0, 0, 1, S_DRAIN,  3'b011, 1, 1, 32'h0000_00FF});
    tbl.push_back('{0, 0, 0, 32'h0, 0, 1, S_UPDATE, 3'b001, 1, 0, 32'h0000_00FF});
    tbl.push_back('{0, 0, 0, 32'h0, 0, 0, S_IDLE,   3'b000, 0, 0, 32'hA5A5_A5A5});

    foreach (tbl[i]) begin
      tick(tbl[i].run, tbl[i].stop, tbl[i].wr, tbl[i].wd, tbl[i].mi, tbl[i].mo);
      chk($sformatf("vec%0d", i),
          mk(tbl[i].st, tbl[i].ctl, tbl[i].pend, tbl[i].infl, 0, 0, tbl[i].mask));
    end

    // Drain timeout with one beat stuck, then cmd_run clears the flag.
    tick(1, 0, 0, 32'h0, 0, 0);
    idle(5);
    tick(0, 0, 0, 32'h0, 1, 0);
    tick(0, 0, 1, 32'h0000_1234, 0, 0);
    idle(DRAIN_TO - 1);
    chk("drain_wait", mk(S_DRAIN, 3'b011, 1, 1, 0, 0, 32'hA5A5_A5A5));
    idle(1);
    chk("timeout", mk(S_UPDATE, 3'b001, 1, 0, 1, 0, 32'hA5A5_A5A5));
    idle(1);
    chk("post_timeout", mk(S_CLEAR, 3'b101, 0, 0, 1, 0, 32'h0000_1234));
    idle(5);
    tick(0, 1, 0, 32'h0, 0, 0);
    idle(1);
    chk("stop_idle", mk(S_IDLE, 3'b000, 0, 0, 1, 0, 32'h0000_1234));
    tick(1, 0, 0, 32'h0, 0, 0);
    chk("run_clears_err", mk(S_CLEAR, 3'b101, 0, 0, 0, 0, 32'h0000_1234));
    idle(5);

    // Underflow and simultaneous in/out.
    tick(0, 0, 0, 32'h0, 0, 1);
    chk("underflow", mk(S_RUN, 3'b010, 0, 0, 0, 1, 32'h0000_1234));
    tick(0, 0, 0, 32'h0, 1, 0);
    tick(0, 0, 0, 32'h0, 1, 1);
    chk("in_out_same", mk(S_RUN, 3'b010, 0, 1, 0, 1, 32'h0000_1234));

    // Asynchronous reset during DRAIN with a pending mask.
    tick(0, 0, 1, 32'hDEAD_BEEF, 0, 0);
    idle(1);
    chk("pre_reset", mk(S_DRAIN, 3'b011, 1, 1, 0, 1, 32'h0000_1234));
    #2 rst = 1;
    #1;
    chk("async_reset", mk(S_IDLE, 3'b000, 0, 0, 0, 0, 32'h0));
    model_reset();
    @(negedge clk);
    rst = 0;
    tick(1, 0, 0, 32'h0, 0, 0);
    idle(5);
    tick(0, 1, 0, 32'h0, 0, 0);
    idle(1);
    chk("shadow_discarded", mk(S_IDLE, 3'b000, 0, 0, 0, 0, 32'h0));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 23) == 0, $urandom_range(0, 15) == 0,
           $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
